// File: rtl/tick_countdown_timer_if.sv
// Tick-enable consumer bus for tick_countdown_timer: control inputs plus status outputs.
// The pause signal exists only when TICK_COUNTDOWN_TIMER_PAUSE_EN is defined.
interface tick_countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             tick;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] value;
`ifdef TICK_COUNTDOWN_TIMER_PAUSE_EN
  logic             pause;
`endif
  logic             busy;
  logic             expired;
  logic [WIDTH-1:0] remaining;

  modport master (
    output tick, start, abort, value,
`ifdef TICK_COUNTDOWN_TIMER_PAUSE_EN
    output pause,
`endif
    input  busy, expired, remaining
  );

  modport slave (
    input  tick, start, abort, value,
`ifdef TICK_COUNTDOWN_TIMER_PAUSE_EN
    input  pause,
`endif
    output busy, expired, remaining
  );
endinterface

// File: rtl/tick_countdown_timer.sv
// Loadable countdown decremented once per divider tick; pulses expired for one cycle on completion.
// Optional macro TICK_COUNTDOWN_TIMER_PAUSE_EN adds a pause input that freezes counting.
module tick_countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  tick_countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] remaining_r;
  logic [WIDTH-1:0] remaining_s;
  logic             busy_r;
  logic             busy_s;
  logic             expired_r;
  logic             expired_s;
  // Set when DONE was entered by a zero load; expired then fires on the DONE exit edge.
  logic             zero_pend_r;
  logic             zero_pend_s;
  logic             tick_ok_s;

  state_t           load_state_s;
  logic [WIDTH-1:0] load_remaining_s;
  logic             load_busy_s;
  logic             load_zero_pend_s;

`ifdef TICK_COUNTDOWN_TIMER_PAUSE_EN
  assign tick_ok_s = bus.tick & ~bus.pause;
`else
  assign tick_ok_s = bus.tick;
`endif

  // Result of a start in any state: zero load goes straight to DONE, otherwise count.
  always_comb begin
    load_state_s     = IDLE;
    load_remaining_s = {WIDTH{1'b0}};
    load_busy_s      = 1'b0;
    load_zero_pend_s = 1'b0;
    if (bus.value == {WIDTH{1'b0}}) begin
      load_state_s     = DONE;
      load_zero_pend_s = 1'b1;
    end else begin
      load_state_s     = COUNT;
      load_remaining_s = bus.value;
      load_busy_s      = 1'b1;
    end
  end

  // Next-state and next-output logic; priority is abort > start > tick.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    busy_s      = busy_r;
    expired_s   = 1'b0;
    zero_pend_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        expired_s   = zero_pend_r;
        state_s     = IDLE;
        remaining_s = {WIDTH{1'b0}};
        busy_s      = 1'b0;
        if (!bus.abort && bus.start) begin
          state_s     = load_state_s;
          remaining_s = load_remaining_s;
          busy_s      = load_busy_s;
          zero_pend_s = load_zero_pend_s;
        end else begin
          zero_pend_s = 1'b0;
        end
      end
      COUNT: begin
        if (bus.abort) begin
          state_s     = IDLE;
          remaining_s = {WIDTH{1'b0}};
          busy_s      = 1'b0;
        end else if (bus.start) begin
          state_s     = load_state_s;
          remaining_s = load_remaining_s;
          busy_s      = load_busy_s;
          zero_pend_s = load_zero_pend_s;
        end else if (tick_ok_s) begin
          if (remaining_r > WIDTH'(1)) begin
            remaining_s = remaining_r - WIDTH'(1);
          end else begin
            state_s     = DONE;
            remaining_s = {WIDTH{1'b0}};
            busy_s      = 1'b0;
            expired_s   = 1'b1;
          end
        end else begin
          state_s = COUNT;
        end
      end
      default: begin
        state_s     = IDLE;
        remaining_s = {WIDTH{1'b0}};
        busy_s      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      remaining_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      expired_r   <= 1'b0;
      zero_pend_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      busy_r      <= busy_s;
      expired_r   <= expired_s;
      zero_pend_r <= zero_pend_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.expired   = expired_r;
  assign bus.remaining = remaining_r;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Scoreboard bench for tick_countdown_timer: driver pushes model expectations, monitor pops and compares.
module tb_tick_countdown_timer;

  localparam int W = 4;

  logic clock;
  logic reset_n;
  logic pause_v;

  tick_countdown_timer_if #(.WIDTH(W)) bus ();

  tick_countdown_timer #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic         busy;
    logic         expired;
    logic [W-1:0] remaining;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: remaining count, whether counting, and a zero-load expiry owed on the next edge.
  int m_cnt        = 0;
  bit m_counting   = 1'b0;
  bit m_zero_owed  = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_cnt       = 0;
    m_counting  = 1'b0;
    m_zero_owed = 1'b0;
  endtask

  // One clock of stimulus: drive at the falling edge, predict the next rising edge.
  task automatic step(input logic t, input logic s, input logic a, input logic [W-1:0] v);
    exp_t e;
    bit   paused;
    bit   exp_pulse;
    @(negedge clock);
    bus.tick  = t;
    bus.start = s;
    bus.abort = a;
    bus.value = v;
`ifdef TICK_COUNTDOWN_TIMER_PAUSE_EN
    bus.pause = pause_v;
    paused    = pause_v;
`else
    paused    = 1'b0;
`endif
    exp_pulse   = m_zero_owed;
    m_zero_owed = 1'b0;
    if (a) begin
      m_counting = 1'b0;
      m_cnt      = 0;
    end else if (s) begin
      if (v == 0) begin
        m_counting  = 1'b0;
        m_cnt       = 0;
        m_zero_owed = 1'b1;
      end else begin
        m_counting = 1'b1;
        m_cnt      = int'(v);
      end
    end else if (m_counting && t && !paused) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_counting = 1'b0;
        exp_pulse  = 1'b1;
      end
    end
    e.busy      = m_counting;
    e.expired   = exp_pulse;
    e.remaining = W'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic run_ticks(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      idle(spacing - 1);
      step(1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  // Monitor: compare every presented output cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("busy", int'(bus.busy), int'(e.busy));
        check("expired", int'(bus.expired), int'(e.expired));
        check("remaining", int'(bus.remaining), int'(e.remaining));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    pause_v   = 1'b0;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.value = '0;
`ifdef TICK_COUNTDOWN_TIMER_PAUSE_EN
    bus.pause = 1'b0;
`endif
    #12;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_expired", int'(bus.expired), 0);
    check("reset_remaining", int'(bus.remaining), 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();

    // Reset mid-count after two ticks of a 5 count.
    step(1'b0, 1'b1, 1'b0, 4'd5);
    run_ticks(2, 4);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_expired", int'(bus.expired), 0);
    check("async_rst_remaining", int'(bus.remaining), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    idle(8);

    // Nominal count of 3 with ticks every 4 clocks.
    step(1'b0, 1'b1, 1'b0, 4'd3);
    run_ticks(3, 4);
    idle(3);

    // Zero load, then full-scale count with no wrap.
    step(1'b0, 1'b1, 1'b0, 4'd0);
    idle(4);
    step(1'b0, 1'b1, 1'b0, 4'd15);
    run_ticks(15, 2);
    idle(3);

    // Abort beats start; abort in idle does nothing.
    step(1'b0, 1'b1, 1'b0, 4'd4);
    run_ticks(1, 4);
    step(1'b0, 1'b1, 1'b1, 4'd7);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 4'd9);
    idle(2);

    // Restart together with a tick: reload wins, no decrement.
    step(1'b0, 1'b1, 1'b0, 4'd6);
    run_ticks(2, 4);
    step(1'b1, 1'b1, 1'b0, 4'd2);
    run_ticks(2, 4);
    idle(3);

    // Back-to-back ticks on consecutive cycles.
    step(1'b0, 1'b1, 1'b0, 4'd3);
    run_ticks(3, 1);
    idle(2);

`ifdef TICK_COUNTDOWN_TIMER_PAUSE_EN
    // Pause holds the count across three ticks.
    step(1'b0, 1'b1, 1'b0, 4'd3);
    run_ticks(1, 4);
    pause_v = 1'b1;
    run_ticks(3, 4);
    pause_v = 1'b0;
    run_ticks(2, 4);
    idle(3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      pause_v = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 2) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 29) == 0),
           W'($urandom_range(0, 15)));
    end
    pause_v = 1'b0;
    idle(20);

    repeat (2) @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
